fpu_issue_ctrl: RTL and testbench

Multicycle FPU issue and stall sequencer in the execute stage. It consumes the per-instruction control produced by the decode stage:
- `alu_fpu_sig`
- 5-bit `alu_cont` op code
- 10-bit thermometer `fpu_stall` latency code

It launches the FPU operation, stalls the front of the pipeline for exactly the encoded latency, and signals completion with the captured destination register. Single-cycle FP ops (compare, sign-inject) pass through with no stall.

---
 rtl/fpu_pkg.sv | 30 +++
 rtl/fpu_issue_ctrl_if.sv | 30 +++
 rtl/therm2lat.sv | 32 +++
 rtl/fpu_issue_ctrl.sv | 104 ++++++++++
 tb/tb_fpu_issue_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the execute-stage FPU issue sequencer:
// op codes, state encoding and latency limits.
package fpu_pkg;

   localparam int unsigned MAX_LAT = 10;

   localparam logic [4:0] FADD   = 5'b10000;
   localparam logic [4:0] FSUB   = 5'b10001;
   localparam logic [4:0] FMUL   = 5'b10010;
   localparam logic [4:0] FDIV   = 5'b10011;
   localparam logic [4:0] FSQRT  = 5'b10100;
   localparam logic [4:0] FEQ    = 5'b10101;
   localparam logic [4:0] FLT    = 5'b10110;
   localparam logic [4:0] FLE    = 5'b10111;
   localparam logic [4:0] FSGNJ  = 5'b11000;
   localparam logic [4:0] FSGNJN = 5'b11001;
   localparam logic [4:0] FSGNJX = 5'b11010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } fpu_state_e;

   // Every FPU op code lives in the upper half of the alu_cont space.
   function automatic logic is_fpu_op(input logic [4:0] cont);
      return cont[4];
   endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Execute-stage <-> FPU issue sequencer bundle. The pipeline side is the
// master; the sequencer is the slave.
interface fpu_issue_ctrl_if #(
   parameter int unsigned LAT_W = 10
);
   logic             issue_valid;
   logic             alu_fpu_sig;
   logic [4:0]       alu_cont;
   logic [LAT_W-1:0] fpu_stall;
   logic [4:0]       rd_e;
   logic             flush;

   logic             stall;
   logic             fpu_start;
   logic [4:0]       fpu_op;
   logic             done;
   logic [4:0]       rd_q;
   logic             busy;
   logic             code_err;

   modport master (
      output issue_valid, alu_fpu_sig, alu_cont, fpu_stall, rd_e, flush,
      input  stall, fpu_start, fpu_op, done, rd_q, busy, code_err
   );

   modport slave (
      input  issue_valid, alu_fpu_sig, alu_cont, fpu_stall, rd_e, flush,
      output stall, fpu_start, fpu_op, done, rd_q, busy, code_err
   );
endinterface

// File: rtl/therm2lat.sv
// Thermometer latency decoder: cycle count from the highest set bit, plus a
// flag for codes that have a hole below that bit.
module therm2lat #(
   parameter int unsigned LAT_W = 10,
   parameter int unsigned N_W   = 4
) (
   input  logic [LAT_W-1:0] code,
   output logic [N_W-1:0]   lat,
   output logic             malformed
);

   logic seen;

   // Scan from the MSB down: the first 1 fixes the latency, any 0 after it
   // means the code was not a clean thermometer.
   always_comb begin
      lat       = '0;
      malformed = 1'b0;
      seen      = 1'b0;
      for (int unsigned k = 0; k < LAT_W; k++) begin
         if (code[LAT_W-1-k]) begin
            if (!seen) begin
               lat = N_W'(LAT_W - k);
            end
            seen = 1'b1;
         end else if (seen) begin
            malformed = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Multicycle FPU issue/stall sequencer: launches an FPU op, holds the front of
// the pipeline for the decoded latency, then flags completion with rd.
module fpu_issue_ctrl
   import fpu_pkg::*;
#(
   parameter int unsigned LAT_W = MAX_LAT,
   parameter int unsigned CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   fpu_issue_ctrl_if.slave      io
);

   logic [CNT_W-1:0] lat_n;
   logic             malformed;
   logic             accept;

   fpu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       fpu_op_q, fpu_op_d;
   logic [4:0]       rd_cap_q, rd_cap_d;
   logic             code_err_q, code_err_d;

   therm2lat #(
      .LAT_W (LAT_W),
      .N_W   (CNT_W)
   ) u_therm2lat (
      .code      (io.fpu_stall),
      .lat       (lat_n),
      .malformed (malformed)
   );

   // Issue is only looked at in IDLE, so an instruction held in execute
   // during BUSY/DONE can never launch a second time.
   assign accept = (state_q == ST_IDLE)
                 && io.issue_valid
                 && io.alu_fpu_sig
                 && is_fpu_op(io.alu_cont)
                 && !io.flush
                 && (lat_n != '0);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      fpu_op_d   = fpu_op_q;
      rd_cap_d   = rd_cap_q;
      code_err_d = code_err_q | (accept & malformed);

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               fpu_op_d = io.alu_cont;
               rd_cap_d = io.rd_e;
               if (lat_n == CNT_W'(1)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_BUSY;
                  cnt_d   = lat_n - CNT_W'(2);
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         fpu_op_q   <= '0;
         rd_cap_q   <= '0;
         code_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fpu_op_q   <= fpu_op_d;
         rd_cap_q   <= rd_cap_d;
         code_err_q <= code_err_d;
      end
   end

   // Launch and the first stall cycle must be visible in the accept cycle
   // itself, hence the combinational term alongside the BUSY state.
   assign io.stall     = accept | (state_q == ST_BUSY);
   assign io.fpu_start = accept;
   assign io.done      = (state_q == ST_DONE);
   assign io.busy      = (state_q != ST_IDLE);
   assign io.fpu_op    = fpu_op_q;
   assign io.rd_q      = rd_cap_q;
   assign io.code_err  = code_err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed scenarios then random traffic, each cycle
// compared against a timeline model of the issue/stall/done schedule.
module tb_fpu_issue_ctrl;
   import fpu_pkg::*;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   fpu_issue_ctrl_if #(.LAT_W(10)) bus ();

   fpu_issue_ctrl #(
      .LAT_W (10),
      .CNT_W (4)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .io   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: an accepted op at cycle t0 with latency n stalls cycles t0..t0+n-1,
   // reports done at t0+n and is free again at t0+n+1.
   bit         m_active = 1'b0;
   int         m_t0     = 0;
   int         m_n      = 0;
   int         cyc      = 0;
   logic [4:0] m_op     = '0;
   logic [4:0] m_rd     = '0;
   logic       m_err    = 1'b0;
   int         starts   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic fp, input logic [4:0] cont,
                        input logic [9:0] code, input logic [4:0] rd, input logic fl);
      bus.issue_valid = v;
      bus.alu_fpu_sig = fp;
      bus.alu_cont    = cont;
      bus.fpu_stall   = code;
      bus.rd_e        = rd;
      bus.flush       = fl;
   endtask

   task automatic step();
      int   n_in;
      int   ph;
      bit   acc;
      bit   mal;
      logic e_stall, e_start, e_done, e_busy;
      @(negedge clk);
      n_in = $clog2(int'(bus.fpu_stall) + 1);
      mal  = (n_in > 0) && (int'(bus.fpu_stall) != ((1 << n_in) - 1));
      acc  = !m_active && bus.issue_valid && bus.alu_fpu_sig && bus.alu_cont[4]
             && !bus.flush && (n_in > 0);
      ph   = cyc - m_t0;
      if (m_active) begin
         e_stall = (ph < m_n);
         e_done  = (ph == m_n);
         e_busy  = 1'b1;
         e_start = 1'b0;
      end else begin
         e_stall = acc;
         e_start = acc;
         e_done  = 1'b0;
         e_busy  = 1'b0;
      end
      chk("stall",     32'(bus.stall),     32'(e_stall));
      chk("fpu_start", 32'(bus.fpu_start), 32'(e_start));
      chk("done",      32'(bus.done),      32'(e_done));
      chk("busy",      32'(bus.busy),      32'(e_busy));
      chk("code_err",  32'(bus.code_err),  32'(m_err));
      chk("fpu_op",    32'(bus.fpu_op),    32'(m_op));
      chk("rd_q",      32'(bus.rd_q),      32'(m_rd));
      if (bus.fpu_start) starts++;
      if (!rstn) begin
         m_active = 1'b0;
         m_op     = '0;
         m_rd     = '0;
         m_err    = 1'b0;
      end else if (m_active) begin
         if (ph == m_n) m_active = 1'b0;
      end else if (acc) begin
         m_active = 1'b1;
         m_t0     = cyc;
         m_n      = n_in;
         m_op     = bus.alu_cont;
         m_rd     = bus.rd_e;
         m_err    = m_err | mal;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      drive(1'b0, 1'b0, 5'd0, 10'd0, 5'd0, 1'b0);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic hold(input logic [4:0] cont, input logic [9:0] code,
                       input logic [4:0] rd, input int k);
      drive(1'b1, 1'b1, cont, code, rd, 1'b0);
      for (int i = 0; i < k; i++) step();
   endtask

   initial begin
      logic [9:0] code;
      logic [4:0] cont;
      rstn = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 10'd0, 5'd0, 1'b0);
      @(posedge clk);
      #1;
      step();
      rstn = 1'b1;
      idle(2);

      // fmul: N = 2
      hold(FMUL, 10'b0000000011, 5'd5, 1);
      idle(3);

      // fdiv held for its whole lifetime: a single launch, done at cycle 10
      starts = 0;
      hold(FDIV, 10'b1111111111, 5'd9, 11);
      idle(2);
      chk("fdiv_starts", 32'(starts), 32'd1);

      // fadd then fsqrt back-to-back in cycle 4
      hold(FADD, 10'b0000000111, 5'd3, 4);
      hold(FSQRT, 10'b0001111111, 5'd17, 8);
      idle(2);

      // zero latency and flushed issue are ignored
      hold(FEQ, 10'd0, 5'd4, 2);
      drive(1'b1, 1'b1, FMUL, 10'b0000000011, 5'd6, 1'b1);
      step();
      idle(2);

      // malformed code: N = 3, sticky error
      hold(FSUB, 10'b0000000101, 5'd11, 4);
      idle(3);

      // reset in cycle 4 of an fdiv, then a clean fmul
      hold(FDIV, 10'b1111111111, 5'd20, 4);
      rstn = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 10'd0, 5'd0, 1'b0);
      step();
      rstn = 1'b1;
      idle(2);
      hold(FMUL, 10'b0000000011, 5'd12, 1);
      idle(3);

      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 5))
            0: code = 10'd0;
            1: code = 10'b0000000011;
            2: code = 10'b0000000111;
            3: code = 10'b0001111111;
            4: code = 10'b1111111111;
            default: code = 10'($urandom);
         endcase
         cont    = 5'($urandom);
         cont[4] = ($urandom_range(0, 3) != 0);
         drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 7) != 0), cont, code,
               5'($urandom), ($urandom_range(0, 9) == 0));
         rstn = ($urandom_range(0, 49) != 0);
         step();
      end
      rstn = 1'b1;
      idle(12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
